seg_scan_driver: RTL and testbench

Multiplexed 4-digit seven-segment scanner on the display side of the vending machine top level. It drives the top-level `seg`/`q` pins from one of four 8-bit quantities: product price, coin total, change and sales total. The selected value is converted to decimal with an iterative shift-add-3 engine and shown on digits 2..0. Digit 3 shows the selector index, so the operator can tell which quantity is on screen.

---
 rtl/seg_pkg.sv | 26 ++
 rtl/bin2bcd_seq.sv | 73 +++++++
 rtl/seg_scan_driver.sv | 134 +++++++++++++
 tb/tb_seg_scan_driver.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan driver:
// active-low glyph table, blank code, conversion FSM states and BCD helper.
package seg_pkg;

    localparam int unsigned IDX_W = 2;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; entry 0 is the rightmost element.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h18, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } conv_state_e;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 converter: 8-bit binary to three BCD digits,
// one LOAD cycle, eight SHIFT cycles and a single-cycle DONE pulse.
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] bin,
    output logic       busy,
    output logic       load,
    output logic       done,
    output logic [3:0] bcd_hun,
    output logic [3:0] bcd_ten,
    output logic [3:0] bcd_unit
);

    conv_state_e state_q, state_d;
    logic [11:0] bcd_q, bcd_d;
    logic [7:0]  bin_q, bin_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [11:0] adj;

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        adj     = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                bcd_d   = '0;
                bin_d   = bin;
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                {bcd_d, bin_d} = {adj[10:0], bin_q, 1'b0};
                cnt_d          = cnt_q + 3'd1;
                if (cnt_q == 3'd7) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bcd_q   <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign load     = (state_q == ST_LOAD);
    assign done     = (state_q == ST_DONE);
    assign bcd_hun  = bcd_q[11:8];
    assign bcd_ten  = bcd_q[7:4];
    assign bcd_unit = bcd_q[3:0];

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment scanner: selected value in decimal on
// digits 2..0, selector index on digit 3. Option: SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned SCAN_HZ = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] sel,
    input  logic [7:0] val0,
    input  logic [7:0] val1,
    input  logic [7:0] val2,
    input  logic [7:0] val3,
    output logic [6:0] seg,
    output logic [3:0] q,
    output logic       busy
);

    localparam int unsigned DIV    = CLK_HZ / SCAN_HZ;
    localparam int unsigned TICK_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [7:0]        val_mux;
    logic [9:0]        key;
    logic [9:0]        snap_q, snap_d;
    logic              force_q, force_d;
    logic [3:0]        hun_q, hun_d, ten_q, ten_d, unit_q, unit_d;
    logic [1:0]        dsel_q, dsel_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [6:0]        seg_q, seg_d;
    logic [3:0]        q_q, q_d;
    logic              conv_busy, conv_load, conv_done;
    logic [3:0]        bcd_hun, bcd_ten, bcd_unit;

    always_comb begin
        val_mux = val0;
        unique case (sel)
            2'd0: val_mux = val0;
            2'd1: val_mux = val1;
            2'd2: val_mux = val2;
            2'd3: val_mux = val3;
            default: val_mux = val0;
        endcase
        key = {sel, val_mux};
    end

    // The engine latches val_mux in the same LOAD cycle that snap_q takes the key,
    // so the snapshot always describes exactly what is being converted.
    bin2bcd_seq u_conv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (force_q || (key != snap_q)),
        .bin      (val_mux),
        .busy     (conv_busy),
        .load     (conv_load),
        .done     (conv_done),
        .bcd_hun  (bcd_hun),
        .bcd_ten  (bcd_ten),
        .bcd_unit (bcd_unit)
    );

    always_comb begin
        snap_d  = snap_q;
        force_d = force_q;
        hun_d   = hun_q;
        ten_d   = ten_q;
        unit_d  = unit_q;
        dsel_d  = dsel_q;
        if (conv_load) begin
            snap_d  = key;
            force_d = 1'b0;
        end
        if (conv_done) begin
            hun_d  = bcd_hun;
            ten_d  = bcd_ten;
            unit_d = bcd_unit;
            dsel_d = snap_q[9:8];
        end
    end

    always_comb begin
        tick_d = tick_q + TICK_W'(1);
        idx_d  = idx_q;
        if (tick_q == TICK_W'(DIV - 1)) begin
            tick_d = '0;
            idx_d  = idx_q + IDX_W'(1);
        end
        q_d = ~(4'b0001 << idx_q);
        unique case (idx_q)
            2'd0: seg_d = SEG_TABLE[unit_q];
            2'd1: seg_d = SEG_TABLE[ten_q];
            2'd2: seg_d = SEG_TABLE[hun_q];
            2'd3: seg_d = SEG_TABLE[{2'b00, dsel_q}];
            default: seg_d = SEG_BLANK;
        endcase
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if ((idx_q == 2'd2) && (hun_q == 4'd0)) seg_d = SEG_BLANK;
        if ((idx_q == 2'd1) && (hun_q == 4'd0) && (ten_q == 4'd0)) seg_d = SEG_BLANK;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snap_q  <= '0;
            force_q <= 1'b1;
            hun_q   <= '0;
            ten_q   <= '0;
            unit_q  <= '0;
            dsel_q  <= '0;
            tick_q  <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_BLANK;
            q_q     <= '1;
        end else begin
            snap_q  <= snap_d;
            force_q <= force_d;
            hun_q   <= hun_d;
            ten_q   <= ten_d;
            unit_q  <= unit_d;
            dsel_q  <= dsel_d;
            tick_q  <= tick_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            q_q     <= q_d;
        end
    end

    assign seg  = seg_q;
    assign q    = q_q;
    assign busy = conv_busy;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (DIV=4): stimulus pushes expected digit
// sets, a monitor pops one per completed conversion and checks the scanned digits.
module tb_seg_scan_driver;

    typedef logic [3:0][6:0] digs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] sel = 2'd0;
    logic [7:0] val0 = 8'd0, val1 = 8'd0, val2 = 8'd0, val3 = 8'd0;
    logic [6:0] seg;
    logic [3:0] q;
    logic       busy;

    int total = 0;
    int bad   = 0;

    digs_t sb[$];

    logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h67};

    seg_scan_driver #(.CLK_HZ(8), .SCAN_HZ(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sel   (sel),
        .val0  (val0),
        .val1  (val1),
        .val2  (val2),
        .val3  (val3),
        .seg   (seg),
        .q     (q),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic digs_t model(input int s, input int v);
        digs_t r;
        int h, t, u;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        r[0] = ~pat[u];
        r[1] = ~pat[t];
        r[2] = ~pat[h];
        r[3] = ~pat[s];
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (h == 0) r[2] = 7'h7F;
        if (h == 0 && t == 0) r[1] = 7'h7F;
`endif
        return r;
    endfunction

    // Monitor
    digs_t      cur;
    int         win = 0;
    int         busy_cnt = 0;
    logic       prev_busy = 1'b0;
    logic [3:0] prev_q = 4'hF;

    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            win       = 0;
            busy_cnt  = 0;
            prev_busy = 1'b0;
            prev_q    = 4'hF;
        end else begin
            if (prev_q != 4'hF && q != prev_q)
                check(q == {prev_q[2:0], prev_q[3]}, "scan_order",
                      32'(q), 32'({prev_q[2:0], prev_q[3]}));
            if (win > 0) begin
                int k;
                k = -1;
                case (q)
                    4'hE: k = 0;
                    4'hD: k = 1;
                    4'hB: k = 2;
                    4'h7: k = 3;
                    default: k = -1;
                endcase
                if (k < 0) check(1'b0, "digit_enable", 32'(q), 32'hE);
                else check(seg == cur[k], $sformatf("digit%0d", k), 32'(seg), 32'(cur[k]));
                win--;
            end
            if (busy) busy_cnt++;
            else if (prev_busy) begin
                check(busy_cnt == 10, "busy_len", 32'(busy_cnt), 32'd10);
                if (sb.size() == 0) check(1'b0, "unexpected_done", 32'd1, 32'd0);
                else begin
                    cur = sb.pop_front();
                    win = 16;
                end
                busy_cnt = 0;
            end
            prev_busy = busy;
            prev_q    = q;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_busy();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (busy) seen = 1'b1;
        end
        check(seen, "busy_start_timeout", 32'(seen), 32'd1);
    endtask

    initial begin
        // Reset with everything zero
        repeat (3) @(posedge clk);
        #1;
        check(q == 4'hF, "rst_q", 32'(q), 32'hF);
        check(seg == 7'h7F, "rst_seg", 32'(seg), 32'h7F);
        check(busy == 1'b0, "rst_busy", 32'(busy), 32'h0);
        sb.push_back(model(0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check(q == 4'hE, "first_q", 32'(q), 32'hE);
        check(seg == 7'h40, "first_seg", 32'(seg), 32'h40);
        check(busy == 1'b1, "first_busy", 32'(busy), 32'h1);
        wait_cyc(40);

        // 207 on coin total
        sel = 2'd1; val1 = 8'd207;
        sb.push_back(model(1, 207));
        wait_cyc(40);

        // Maximum value on sales total
        sel = 2'd3; val3 = 8'd255;
        sb.push_back(model(3, 255));
        wait_cyc(40);

        // Change while converting: 12 then 99, never a mixed value
        sel = 2'd0; val0 = 8'd12;
        sb.push_back(model(0, 12));
        wait_busy();
        wait_cyc(2);
        val0 = 8'd99;
        sb.push_back(model(0, 99));
        wait_cyc(50);

        // Leading-zero cases
        sel = 2'd2; val2 = 8'd5;
        sb.push_back(model(2, 5));
        wait_cyc(40);
        val2 = 8'd40;
        sb.push_back(model(2, 40));
        wait_cyc(40);

        // Reset during SHIFT aborts the conversion
        sel = 2'd3;
        wait_busy();
        wait_cyc(3);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check(q == 4'hF, "midrst_q", 32'(q), 32'hF);
        check(seg == 7'h7F, "midrst_seg", 32'(seg), 32'h7F);
        check(busy == 1'b0, "midrst_busy", 32'(busy), 32'h0);
        sb.push_back(model(3, 255));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check(q == 4'hE, "postrst_q", 32'(q), 32'hE);
        check(seg == 7'h40, "postrst_seg_disp_cleared", 32'(seg), 32'h40);
        wait_cyc(40);

        check(sb.size() == 0, "scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
